// File: rtl/fsm_seq_checker_if.sv
// Control and observation bus between the stimulus/counter side and the
// sequence checker: the counter controls plus the counter's output.
interface fsm_seq_checker_if #(
  parameter int WIDTH = 4
);
  logic             ce;
  logic             load;
  logic             up;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] seq;

  modport master (output ce, load, up, data, seq);
  modport slave  (input  ce, load, up, data, seq);
endinterface

// File: rtl/fsm_seq_checker.sv
// Monitor for the loadable up/down sequence counter. It tracks a reference
// model of the counter and flags every cycle where seq deviates from it,
// keeping saturating check/error counts.
// Optional macro SEQ_CHK_CAPTURE_EN: capture expected/observed values at the
// first mismatch after reset into first_exp/first_act.
module fsm_seq_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chk_en,
  fsm_seq_checker_if.slave     bus,
  output logic                 err,
  output logic                 fail,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     chk_cnt,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_act
);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t           state;
  logic [WIDTH-1:0] exp_val;

  // Reference counter step: load beats ce, ce steps by one with wrap, else hold.
  function automatic logic [WIDTH-1:0] next_val(
    input logic [WIDTH-1:0] v,
    input logic             ld,
    input logic             en,
    input logic             dir,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = v;
    if (ld)
      r = d;
    else if (en && dir)
      r = v + 1'b1;
    else if (en)
      r = v - 1'b1;
    return r;
  endfunction

`ifndef SEQ_CHK_CAPTURE_EN
  assign first_exp = '0;
  assign first_act = '0;
`endif

  // Checker FSM: IDLE seeds the model from seq, TRACK compares and counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      exp_val <= '0;
      err     <= 1'b0;
      fail    <= 1'b0;
      err_cnt <= '0;
      chk_cnt <= '0;
`ifdef SEQ_CHK_CAPTURE_EN
      first_exp <= '0;
      first_act <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          err     <= 1'b0;
          exp_val <= next_val(bus.seq, bus.load, bus.ce, bus.up, bus.data);
          state   <= TRACK;
        end
        TRACK: begin
          if (chk_en) begin
            if (chk_cnt != '1)
              chk_cnt <= chk_cnt + 1'b1;
            if (bus.seq == exp_val) begin
              err     <= 1'b0;
              exp_val <= next_val(exp_val, bus.load, bus.ce, bus.up, bus.data);
            end else begin
              // Resync to the observed value so one fault is counted once.
              err     <= 1'b1;
              fail    <= 1'b1;
              exp_val <= next_val(bus.seq, bus.load, bus.ce, bus.up, bus.data);
              if (err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
`ifdef SEQ_CHK_CAPTURE_EN
              if (!fail) begin
                first_exp <= exp_val;
                first_act <= bus.seq;
              end
`endif
            end
          end else begin
            err     <= 1'b0;
            exp_val <= next_val(bus.seq, bus.load, bus.ce, bus.up, bus.data);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
